// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider issue controller.
// The divide-by-zero bypass in div_issue_ctrl is selected by DIV_ZERO_FAST_EN.
package div_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_BUSY  = 2'b01,
      ST_ABORT = 2'b10,
      ST_HOLD  = 2'b11
   } div_state_t;

   localparam logic [1:0] OP_DIV_W  = 2'b00;
   localparam logic [1:0] OP_MOD_W  = 2'b01;
   localparam logic [1:0] OP_DIV_WU = 2'b10;
   localparam logic [1:0] OP_MOD_WU = 2'b11;

   localparam int WDOG_W = 6;

   // op[0] picks remainder over quotient; the divider already applies sign rules
   function automatic logic [31:0] select_result(input logic [1:0] op,
                                                 input logic [31:0] quo,
                                                 input logic [31:0] rem);
      return op[0] ? rem : quo;
   endfunction

   // Architectural x/0 result: all-ones quotient, remainder equals the dividend
   function automatic logic [31:0] zero_div_result(input logic [1:0] op,
                                                   input logic [31:0] dividend);
      return op[0] ? dividend : 32'hFFFF_FFFF;
   endfunction

endpackage

// File: rtl/div_issue_ctrl.sv
// Issue/hold controller between the EXE pipeline and an external multi-cycle divider.
// Define DIV_ZERO_FAST_EN to answer divide-by-zero requests without starting the divider.
module div_issue_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int DIV_LAT_MAX = 40
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_src1,
   input  logic [31:0] req_src2,
   output logic        req_ready,
   input  logic        flush,
   output logic        res_valid,
   output logic [31:0] res_data,
   input  logic        res_ready,
   output logic        div_en,
   output logic        div_signed,
   output logic [31:0] div_x,
   output logic [31:0] div_y,
   input  logic [31:0] div_s,
   input  logic [31:0] div_r,
   input  logic        div_done,
   output logic        err_timeout
);

   div_state_t        state;
   logic [1:0]        op_q;
   logic [WDOG_W-1:0] wdog;
   logic [WDOG_W-1:0] wdog_inc;
   logic              wdog_hit;
   logic              accept;

   // Handshake outputs are pure decodes of the state register, so reset reaches them asynchronously
   assign req_ready = (state == ST_IDLE);
   assign div_en    = (state == ST_BUSY);
   assign res_valid = (state == ST_HOLD);

   assign accept   = req_valid && req_ready && !flush;
   assign wdog_inc = wdog + 1'b1;
   assign wdog_hit = (wdog_inc == WDOG_W'(DIV_LAT_MAX));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         op_q        <= OP_DIV_W;
         div_x       <= '0;
         div_y       <= '0;
         div_signed  <= 1'b0;
         res_data    <= '0;
         wdog        <= '0;
         err_timeout <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q       <= req_op;
                  div_x      <= req_src1;
                  div_y      <= req_src2;
                  div_signed <= ~req_op[1];
                  wdog       <= '0;
`ifdef DIV_ZERO_FAST_EN
                  if (req_src2 == 32'd0) begin
                     res_data <= zero_div_result(req_op, req_src1);
                     state    <= ST_HOLD;
                  end else begin
                     state <= ST_BUSY;
                  end
`else
                  state <= ST_BUSY;
`endif
               end
            end
            ST_BUSY: begin
               wdog <= wdog_inc;
               // Flush outranks a completing divide; a late div_done is simply ignored
               if (flush) begin
                  state <= ST_ABORT;
               end else if (div_done) begin
                  res_data <= select_result(op_q, div_s, div_r);
                  state    <= ST_HOLD;
               end else if (wdog_hit) begin
                  err_timeout <= 1'b1;
                  state       <= ST_ABORT;
               end
            end
            ST_ABORT: begin
               state <= ST_IDLE;
            end
            ST_HOLD: begin
               if (flush || res_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural divider stub and a result scoreboard.
module tb_div_issue_ctrl;
   import div_ctrl_pkg::*;

   logic        clk;
   logic        resetn;
   logic        req_valid;
   logic [1:0]  req_op;
   logic [31:0] req_src1;
   logic [31:0] req_src2;
   logic        req_ready;
   logic        flush;
   logic        res_valid;
   logic [31:0] res_data;
   logic        res_ready;
   logic        div_en;
   logic        div_signed;
   logic [31:0] div_x;
   logic [31:0] div_y;
   logic [31:0] div_s;
   logic [31:0] div_r;
   logic        div_done;
   logic        err_timeout;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb[$];

   int          div_lat = 5;
   bit          no_done = 1'b0;
   int          dcnt = 0;
   int          en_cnt = 0;

   div_issue_ctrl #(.DIV_LAT_MAX(40)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
      .req_ready(req_ready), .flush(flush),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .div_en(div_en), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
      .div_s(div_s), .div_r(div_r), .div_done(div_done), .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference divide: RISC-V rules for x/0 and signed overflow
   function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] q;
      logic [31:0] r;
      if (y == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = x;
      end else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else if (sgn) begin
         q = $signed(x) / $signed(y);
         r = $signed(x) % $signed(y);
      end else begin
         q = x / y;
         r = x % y;
      end
      return {q, r};
   endfunction

   function automatic logic [31:0] exp_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] t;
      t = ref_div(~op[1], a, b);
      return op[0] ? t[31:0] : t[63:32];
   endfunction

   // Divider stub: answers div_lat cycles into a run of div_en, or never when no_done is set
   always @(posedge clk) begin
      if (div_en && !no_done) begin
         if (dcnt == div_lat - 1) begin
            logic [63:0] qr;
            qr = ref_div(div_signed, div_x, div_y);
            div_done <= 1'b1;
            div_s    <= qr[63:32];
            div_r    <= qr[31:0];
            dcnt     <= 0;
         end else begin
            div_done <= 1'b0;
            dcnt     <= dcnt + 1;
         end
      end else begin
         div_done <= 1'b0;
         dcnt     <= 0;
      end
      if (div_en) en_cnt <= en_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit push, input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_src1  = a;
      req_src2  = b;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (push) sb.push_back(exp);
      chk({tag, "_acc_rdy"}, {31'd0, req_ready}, 32'd0);
      chk({tag, "_x"}, div_x, a);
      chk({tag, "_y"}, div_y, b);
      chk({tag, "_sgn"}, {31'd0, div_signed}, {31'd0, ~op[1]});
   endtask

   task automatic collect(input int hold_cycles, input string tag);
      int          n;
      bit          rdy_low;
      bit          stable;
      bit          ops_stable;
      logic [31:0] exp;
      logic [31:0] first;
      logic [31:0] x0;
      logic [31:0] y0;
      n = 0;
      rdy_low = 1'b1;
      stable = 1'b1;
      ops_stable = 1'b1;
      x0 = div_x;
      y0 = div_y;
      @(negedge clk);
      while (!res_valid && n < 200) begin
         if (req_ready) rdy_low = 1'b0;
         if (div_en && (div_x !== x0 || div_y !== y0)) ops_stable = 1'b0;
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
      chk({tag, "_ops_stable"}, {31'd0, ops_stable}, 32'd1);
      if (sb.size() == 0) begin
         chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
         return;
      end
      exp = sb.pop_front();
      if (!res_valid) return;
      chk({tag, "_data"}, res_data, exp);
      first = res_data;
      repeat (hold_cycles) begin
         @(negedge clk);
         if (!res_valid || res_data !== first || req_ready) stable = 1'b0;
      end
      if (hold_cycles > 0) chk({tag, "_hold_stable"}, {31'd0, stable}, 32'd1);
      if (req_ready) rdy_low = 1'b0;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      chk({tag, "_busy_not_ready"}, {31'd0, rdy_low}, 32'd1);
      chk({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
      chk({tag, "_idle_nvalid"}, {31'd0, res_valid}, 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int          n;
      int          en0;
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;

      resetn = 1'b0;
      req_valid = 1'b0;
      req_op = 2'b00;
      req_src1 = '0;
      req_src2 = '0;
      flush = 1'b0;
      res_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_res_data", res_data, 32'd0);
      chk("rst_div_en", {31'd0, div_en}, 32'd0);
      chk("rst_div_x", div_x, 32'd0);
      chk("rst_div_y", div_y, 32'd0);
      chk("rst_div_signed", {31'd0, div_signed}, 32'd0);
      chk("rst_err", {31'd0, err_timeout}, 32'd0);
      resetn = 1'b1;

      // Signed / unsigned vectors with hand-derived results
      issue(OP_DIV_W, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1, "divw_m7_2");
      collect(0, "divw_m7_2");
      issue(OP_MOD_W, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1, "modw_m7_2");
      collect(0, "modw_m7_2");
      issue(OP_DIV_WU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b1, "divwu_m7_2");
      collect(0, "divwu_m7_2");
      issue(OP_MOD_WU, 32'hFFFF_FFF9, 32'd2, 32'd1, 1'b1, "modwu_m7_2");
      collect(0, "modwu_m7_2");
      issue(OP_DIV_W, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "divw_ovf");
      collect(0, "divw_ovf");
      issue(OP_MOD_W, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, "modw_ovf");
      collect(0, "modw_ovf");

      // Consumer stalls for 5 cycles
      issue(OP_DIV_WU, 32'd1000, 32'd3, 32'd333, 1'b1, "stall5");
      collect(5, "stall5");

      // Flush 10 cycles into BUSY
      div_lat = 20;
      issue(OP_DIV_W, 32'd99, 32'd9, 32'd0, 1'b0, "flush_busy");
      repeat (10) @(negedge clk);
      chk("flush_busy_en_before", {31'd0, div_en}, 32'd1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("abort_div_en", {31'd0, div_en}, 32'd0);
      chk("abort_not_ready", {31'd0, req_ready}, 32'd0);
      chk("abort_nvalid", {31'd0, res_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk("abort_to_idle", {31'd0, req_ready}, 32'd1);
      chk("abort_idle_en", {31'd0, div_en}, 32'd0);
      chk("abort_idle_nvalid", {31'd0, res_valid}, 32'd0);
      div_lat = 5;
      issue(OP_DIV_W, 32'd100, 32'd7, 32'd14, 1'b1, "after_flush");
      collect(0, "after_flush");

      // Request together with flush in IDLE is dropped
      @(negedge clk);
      req_valid = 1'b1;
      req_op = OP_DIV_W;
      req_src1 = 32'd55;
      req_src2 = 32'd5;
      flush = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      flush = 1'b0;
      chk("idle_flush_ready", {31'd0, req_ready}, 32'd1);
      chk("idle_flush_en", {31'd0, div_en}, 32'd0);

      // Flush while the result is held
      issue(OP_DIV_W, 32'd50, 32'd5, 32'd0, 1'b0, "flush_hold");
      n = 0;
      while (!res_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("flush_hold_valid", {31'd0, res_valid}, 32'd1);
      chk("flush_hold_data", res_data, 32'd10);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_hold_nvalid", {31'd0, res_valid}, 32'd0);
      chk("flush_hold_ready", {31'd0, req_ready}, 32'd1);

      // Flush coinciding with div_done
      issue(OP_DIV_W, 32'd77, 32'd7, 32'd0, 1'b0, "flush_done");
      n = 0;
      while (!div_done && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("flush_done_seen", {31'd0, div_done}, 32'd1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_done_nvalid", {31'd0, res_valid}, 32'd0);
      chk("flush_done_abort", {31'd0, req_ready}, 32'd0);
      chk("flush_done_en", {31'd0, div_en}, 32'd0);
      @(posedge clk);
      #1;
      chk("flush_done_idle", {31'd0, req_ready}, 32'd1);
      chk("flush_done_nvalid2", {31'd0, res_valid}, 32'd0);

      // Random operand sweep
      for (int i = 0; i < 6; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = (i == 0) ? 32'd3 : ($urandom >> $urandom_range(0, 28));
         div_lat = $urandom_range(1, 8);
         issue(rop, ra, rb, exp_res(rop, ra, rb), 1'b1, "rand");
         collect(i % 3, "rand");
      end
      div_lat = 5;

      // Divide by zero
      en0 = en_cnt;
      issue(OP_MOD_WU, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b1, "modwu_z");
`ifdef DIV_ZERO_FAST_EN
      chk("modwu_z_fast_valid", {31'd0, res_valid}, 32'd1);
      chk("modwu_z_fast_data", res_data, 32'h0000_1234);
`endif
      collect(0, "modwu_z");
`ifdef DIV_ZERO_FAST_EN
      chk("modwu_z_no_en", 32'(en_cnt - en0), 32'd0);
`endif
      issue(OP_DIV_W, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, "divw_z");
      collect(0, "divw_z");

      // Watchdog timeout
      chk("pre_timeout_err", {31'd0, err_timeout}, 32'd0);
      no_done = 1'b1;
      issue(OP_DIV_W, 32'd1, 32'd1, 32'd0, 1'b0, "timeout");
      n = 0;
      @(negedge clk);
      while (div_en && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("timeout_busy_cycles", 32'(n), 32'd40);
      chk("timeout_err", {31'd0, err_timeout}, 32'd1);
      chk("timeout_abort", {31'd0, req_ready}, 32'd0);
      chk("timeout_nvalid", {31'd0, res_valid}, 32'd0);
      @(negedge clk);
      chk("timeout_idle", {31'd0, req_ready}, 32'd1);
      no_done = 1'b0;
      issue(OP_DIV_W, 32'd100, 32'd7, 32'd14, 1'b1, "post_timeout");
      collect(0, "post_timeout");
      chk("timeout_sticky", {31'd0, err_timeout}, 32'd1);

      // Asynchronous reset in the middle of BUSY
      div_lat = 20;
      issue(OP_DIV_WU, 32'd900, 32'd4, 32'd0, 1'b0, "async_rst");
      repeat (3) @(negedge clk);
      chk("async_rst_en_before", {31'd0, div_en}, 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      chk("async_rst_en", {31'd0, div_en}, 32'd0);
      chk("async_rst_ready", {31'd0, req_ready}, 32'd1);
      chk("async_rst_err", {31'd0, err_timeout}, 32'd0);
      chk("async_rst_data", res_data, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      div_lat = 5;
      issue(OP_MOD_W, 32'd100, 32'd7, 32'd2, 1'b1, "after_rst");
      collect(0, "after_rst");

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 SHALL have parameter DIV_LAT_MAX, default 40, meaning the maximum number of BUSY cycles allowed before a timeout is flagged.
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1 bit: pipeline divide request.
REQ-005 SHALL have port req_op, input, 2 bits: 00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu.
REQ-006 SHALL have ports req_src1 (dividend) and req_src2 (divisor), input, 32 bits each.
REQ-007 SHALL have port req_ready, output, 1 bit: controller can accept a request.
REQ-008 SHALL have port flush, input, 1 bit: pipeline cancel.
REQ-009 SHALL have ports res_valid (output, 1 bit), res_data (output, 32 bits) and res_ready (input, 1 bit): the result handshake.
REQ-010 SHALL have divider-side ports div_en (output, 1), div_signed (output, 1), div_x and div_y (output, 32), div_s and div_r (input, 32), and div_done (input, 1).
REQ-011 SHALL have port err_timeout, output, 1 bit: sticky watchdog flag.

Function
REQ-012 SHALL implement the states IDLE, BUSY, ABORT and HOLD.
REQ-013 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid&&req_ready&&!flush.
REQ-014 On acceptance, SHALL register the operands and the op into local registers, then go to BUSY; div_x, div_y and div_signed (= ~req_op[1]) SHALL be driven only from these registers and held stable until the state leaves BUSY.
REQ-015 SHALL drive div_en=1 exactly when the state is BUSY.
REQ-016 In BUSY with div_done=1, SHALL capture div_s (when op[0]=0) or div_r (when op[0]=1) into res_data, then go to HOLD; div_en SHALL be 0 on the next cycle so the divider rearms.
REQ-017 In HOLD, SHALL drive res_valid=1 with res_data stable; on res_ready=1, SHALL go to IDLE.
REQ-018 Because of REQ-013, there SHALL be no back-to-back issue: the next request can be accepted at the earliest in the cycle after the HOLD handshake.
REQ-019 On flush in BUSY, SHALL go to ABORT; ABORT SHALL hold div_en=0 for exactly one cycle and then go to IDLE; no result is produced.
REQ-020 On flush in HOLD, SHALL discard the result and go to IDLE.
REQ-021 On flush in IDLE, any simultaneous request SHALL be ignored.
REQ-022 If flush and div_done occur in the same cycle, flush SHALL win.
REQ-023 SHALL maintain a 6-bit watchdog counter, cleared on entry to BUSY and incremented each BUSY cycle.
REQ-024 When the watchdog count reaches DIV_LAT_MAX without div_done, SHALL set err_timeout, go to ABORT, and produce no result.
REQ-025 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL return quotient 0x80000000 and remainder 0, as supplied by the divider.
REQ-026 res_data SHALL be exactly div_s or div_r; no sign correction is done in this block.

Reset
REQ-027 While resetn=0, SHALL set: state IDLE, req_ready=1, res_valid=0, res_data=0, div_en=0, div_x=0, div_y=0, div_signed=0, err_timeout=0, watchdog=0.
REQ-028 Reset asserted mid-BUSY SHALL drop div_en immediately, through the asynchronous path.

Configuration
REQ-029 SHALL use the macro DIV_ZERO_FAST_EN to compile a divide-by-zero bypass in or out.
REQ-030 With DIV_ZERO_FAST_EN defined, an accepted request with req_src2=0 SHALL skip BUSY and go directly to HOLD, with res_data = 0xFFFFFFFF for div ops and res_data = req_src1 for mod ops; res_valid SHALL rise on the cycle after acceptance and div_en SHALL stay 0.
REQ-031 Without DIV_ZERO_FAST_EN, divisor 0 SHALL go through the divider like any other value, and its result SHALL be passed through unchanged.

Structure
REQ-032 Package div_ctrl_pkg SHALL hold the state enum, the req_op encodings (OP_DIV_W, OP_MOD_W, OP_DIV_WU, OP_MOD_WU) and the watchdog width constant.
REQ-033 SHALL contain no sub-module; the divider SHALL be instantiated by the parent EXE stage and connected through the div_* ports.

Verification
REQ-034 div.w with src1=0xFFFFFFF9 (-7) and src2=2 -> res_data=0xFFFFFFFD (-3); mod.w on the same operands -> res_data=0xFFFFFFFF (-1).
REQ-035 div.wu with src1=0xFFFFFFF9 and src2=2 -> res_data=0x7FFFFFFC; req_ready=0 from acceptance until the HOLD handshake.
REQ-036 Flush 10 cycles into BUSY -> ABORT with div_en=0 for exactly one cycle, then IDLE, no res_valid; a following div.w 100/7 -> 14.
REQ-037 Result with res_ready held 0 for 5 cycles -> res_valid and res_data stable throughout, then IDLE on the cycle after res_ready=1.
REQ-038 div_done tied 0 -> err_timeout=1 after 40 BUSY cycles, then ABORT and IDLE; the flag stays set until reset.
REQ-039 With DIV_ZERO_FAST_EN: mod.wu 0x1234/0 -> res_data=0x1234 one cycle after acceptance, div_en never high.
